rx_frame_unpacker: RTL

RX_FRAME_UNPACKER -- requirements
Module: rx_frame_unpacker

---
 rtl/comms_pkg.sv | 19 +
 rtl/rx_frame_unpacker_if.sv | 40 ++++
 rtl/frame_csum8.sv | 27 ++
 rtl/rx_frame_unpacker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/comms_pkg.sv
// ----------------------------------------------------------------------------
// comms_pkg
// Shared definitions for the receive-side frame path.
//   FRAME_BITS     : width of one received frame (256 bits)
//   FRAME_BYTES    : bytes per frame (FRAME_BITS / 8 = 32)
//   unpack_state_t : rx_frame_unpacker FSM states
// ----------------------------------------------------------------------------
package comms_pkg;

  localparam int FRAME_BITS  = 256;
  localparam int FRAME_BYTES = FRAME_BITS / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // waiting for a frame event
    STREAM = 2'd1,  // presenting held bytes to the consumer
    CHECK  = 2'd2   // one-cycle gap after the last byte (checksum compare)
  } unpack_state_t;

endpackage : comms_pkg

// File: rtl/rx_frame_unpacker_if.sv
// ----------------------------------------------------------------------------
// rx_frame_unpacker_if
// Frame-in / byte-out bundle of rx_frame_unpacker.
//   frameIn     : 256-bit frame from the serial receiver
//   frameStrobe : frame-available level; a 0->1 transition marks a new frame
//   byteOut     : current output byte
//   byteValid   : byteOut is valid
//   byteReady   : consumer accepts byteOut
//   byteLast    : high with the final streamed byte of a frame
// Modports: master = the unpacker, slave = the receiver/consumer side.
// ----------------------------------------------------------------------------
interface rx_frame_unpacker_if;
  import comms_pkg::*;

  logic [FRAME_BITS-1:0] frameIn;
  logic                  frameStrobe;
  logic [7:0]            byteOut;
  logic                  byteValid;
  logic                  byteReady;
  logic                  byteLast;

  modport master (
    input  frameIn,
    input  frameStrobe,
    input  byteReady,
    output byteOut,
    output byteValid,
    output byteLast
  );

  modport slave (
    output frameIn,
    output frameStrobe,
    output byteReady,
    input  byteOut,
    input  byteValid,
    input  byteLast
  );

endinterface : rx_frame_unpacker_if

// File: rtl/frame_csum8.sv
// ----------------------------------------------------------------------------
// frame_csum8
// 8-bit modular sum of the first FRAME_BYTES-1 bytes of a frame (byte 0 in
// bits [7:0]). Only built when UNPACK_CHECKSUM_EN is defined.
//   data : bytes 0..30 of the held frame
//   sum  : sum of those bytes mod 256
// ----------------------------------------------------------------------------
`ifdef UNPACK_CHECKSUM_EN
module frame_csum8
  import comms_pkg::*;
(
  input  logic [FRAME_BITS-9:0] data,
  output logic [7:0]            sum
);

  localparam int N_BYTES = FRAME_BYTES - 1;

  // Plain adder chain; carries out of bit 7 are discarded (mod 256).
  always_comb begin
    sum = 8'h00;
    for (int i = 0; i < N_BYTES; i++) begin
      sum = sum + data[8*i +: 8];
    end
  end

endmodule : frame_csum8
`endif

// File: rtl/rx_frame_unpacker.sv
// ----------------------------------------------------------------------------
// rx_frame_unpacker
// Captures a 256-bit frame on a rising edge of frameStrobe and streams it out
// one byte per valid/ready handshake, byte 0 (bits [7:0]) first. Frame events
// that arrive while a frame is held or streaming are dropped and counted.
//
// Ports
//   clk        : system clock, all logic on posedge
//   rst        : synchronous, active-high reset
//   bus        : rx_frame_unpacker_if.master (frameIn/frameStrobe in,
//                byteOut/byteValid/byteLast out, byteReady in)
//   busy       : a frame is held or streaming (STREAM or CHECK)
//   overflow   : sticky, set when a frame is dropped, cleared only by rst
//   dropCount  : dropped-frame count, saturates at all-ones
//   csumErr    : checksum mismatch for the last completed frame
//
// Build option
//   UNPACK_CHECKSUM_EN : byte 31 is a checksum over bytes 0..30; only bytes
//                        0..30 are streamed and csumErr is updated in CHECK.
//                        Undefined: all 32 bytes stream, csumErr tied to 0.
// ----------------------------------------------------------------------------
module rx_frame_unpacker #(
  parameter int DROP_CNT_W  = 8,
  parameter int FRAME_BYTES = comms_pkg::FRAME_BYTES  // must stay 256 / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rx_frame_unpacker_if.master   bus,
  output logic                  busy,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] dropCount,
  output logic                  csumErr
);

  localparam int IDX_W = $clog2(FRAME_BYTES);
`ifdef UNPACK_CHECKSUM_EN
  localparam int LAST_IDX = FRAME_BYTES - 2;
`else
  localparam int LAST_IDX = FRAME_BYTES - 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX_V = IDX_W'(LAST_IDX);

  comms_pkg::unpack_state_t state, state_next;

  logic [comms_pkg::FRAME_BITS-1:0] hold;
  logic [IDX_W-1:0]                 idx;

  logic strobe_q;
  logic strobe_armed;
  logic frame_evt;
  logic handshake;
  logic load;
  logic advance;
  logic drop;

  // --------------------------------------------------------------------------
  // Strobe edge detect
  // strobe_armed blocks a strobe that is already high when reset releases
  // from looking like a fresh 0->1 edge; the strobe must be seen low first.
  // --------------------------------------------------------------------------
  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q     <= 1'b0;
      strobe_armed <= 1'b0;
    end else begin
      strobe_q <= bus.frameStrobe;
      if (!bus.frameStrobe) begin
        strobe_armed <= 1'b1;
      end
    end
  end

  assign frame_evt = bus.frameStrobe & ~strobe_q & strobe_armed;
  assign handshake = bus.byteValid & bus.byteReady;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= comms_pkg::IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and datapath strobes
  // --------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    drop       = 1'b0;

    unique case (state)
      comms_pkg::IDLE: begin
        if (frame_evt) begin
          load       = 1'b1;
          state_next = comms_pkg::STREAM;
        end
      end

      comms_pkg::STREAM: begin
        drop = frame_evt;
        if (handshake) begin
          if (idx == LAST_IDX_V) begin
            state_next = comms_pkg::CHECK;
          end else begin
            advance = 1'b1;
          end
        end
      end

      comms_pkg::CHECK: begin
        // Still busy here: a new frame only lands once we are back in IDLE.
        drop       = frame_evt;
        state_next = comms_pkg::IDLE;
      end

      default: begin
        state_next = comms_pkg::IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Hold register, byte index and drop bookkeeping
  // --------------------------------------------------------------------------
  // NOTE: the 256-bit hold register is deliberately reset so byteOut and the
  // checksum never expose stale data from before reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      idx       <= '0;
      overflow  <= 1'b0;
      dropCount <= '0;
    end else begin
      if (load) begin
        hold <= bus.frameIn;
        idx  <= '0;
      end else if (advance) begin
        idx <= idx + IDX_W'(1);
      end

      // A dropped frame never touches hold or idx.
      if (drop) begin
        overflow <= 1'b1;
        if (dropCount != '1) begin
          dropCount <= dropCount + DROP_CNT_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: byte mux is forced to zero outside STREAM
  // --------------------------------------------------------------------------
  assign bus.byteValid = (state == comms_pkg::STREAM);
  assign bus.byteLast  = bus.byteValid & (idx == LAST_IDX_V);
  assign bus.byteOut   = bus.byteValid ? hold[{idx, 3'b000} +: 8] : 8'h00;
  assign busy          = (state != comms_pkg::IDLE);

  // --------------------------------------------------------------------------
  // Optional checksum over bytes 0..30 against byte 31
  // --------------------------------------------------------------------------
`ifdef UNPACK_CHECKSUM_EN
  logic [7:0] csum;

  frame_csum8 u_csum (
    .data (hold[comms_pkg::FRAME_BITS-9:0]),
    .sum  (csum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      csumErr <= 1'b0;
    end else if (state == comms_pkg::CHECK) begin
      csumErr <= (csum != hold[comms_pkg::FRAME_BITS-1 -: 8]);
    end
  end
`else
  assign csumErr = 1'b0;
`endif

endmodule : rx_frame_unpacker
